// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer (registered ready_d), flush and saturating stall counter.
// All state updates on the falling edge of clk_i; rst_n_i is async active-low.
// Ports:
//   clk_i, rst_n_i               clock / reset
//   valid_d, ready_d             upstream handshake
//   ctrl_d, data_d, rd_d         upstream payload
//   flush_i                      drop all held entries and the incoming one
//   valid_q, ready_q             downstream handshake
//   ctrl_q, data_q, rd_q         downstream payload (ctrl_q masked by valid_q)
//   stall_cnt_o                  cycles with valid_q=1 and ready_q=0 (saturating)
module pipe_stage_reg #(
  parameter int unsigned CTRL_W         = 8,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned RD_W           = 5,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_d,
  output logic              ready_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic [RD_W-1:0]   rd_d,
  input  logic              flush_i,
  output logic              valid_q,
  input  logic              ready_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q,
  output logic [RD_W-1:0]   rd_q,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             in_ent;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               in_c, out_c;

  assign in_ent = '{ctrl: ctrl_d, data: data_d, rd: rd_d};
  assign in_c   = valid_d & ready_d;
  assign out_c  = valid_q & ready_q;

  // State and payload registers (falling edge)
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
    end
  end

  // Next-state, payload movement and stall counting
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_c) begin
          state_d = ST_FULL;
          main_d  = in_ent;
        end
      end
      ST_FULL: begin
        if (in_c && out_c) begin
          main_d = in_ent;
        end else if (out_c) begin
          state_d = ST_EMPTY;
        end else if (in_c && (SKID != 0)) begin
          state_d = ST_SKID;
          skid_d  = in_ent;
        end
      end
      ST_SKID: begin
        // ready_d is low here, so only the drain path exists
        if (out_c) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides every transfer; the stall in that cycle still counts
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
      end else begin
        main_d = main_q;
      end
    end

    if (valid_q && !ready_q && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    rdy_d = (state_d != ST_SKID);
  end

  // Output decode
  always_comb begin
    valid_q     = (state_q != ST_EMPTY);
    ready_d     = (SKID != 0) ? rdy_q : (ready_q | ~valid_q);
    ctrl_q      = valid_q ? main_q.ctrl : '0;
    data_q      = main_q.data;
    rd_q        = main_q.rd;
    stall_cnt_o = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances share one stimulus stream.
//   u_a: SKID=1, CLEAR_ON_FLUSH=1, CNT_W=16
//   u_b: SKID=0, CLEAR_ON_FLUSH=0, CNT_W=3
// A FIFO-level model per instance predicts outputs; directed literals pin it.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_d = 1'b0;
  logic [7:0]  ctrl_d = '0;
  logic [63:0] data_d = '0;
  logic [4:0]  rd_d = '0;
  logic        flush = 1'b0;
  logic        ready_q = 1'b0;

  logic        rdy_a, vq_a, rdy_b, vq_b;
  logic [7:0]  ctrl_a, ctrl_b;
  logic [63:0] data_a, data_b;
  logic [4:0]  rd_a, rd_b;
  logic [15:0] stall_a;
  logic [2:0]  stall_b;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .RD_W(5), .SKID(1),
                   .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d(valid_d), .ready_d(rdy_a),
    .ctrl_d(ctrl_d), .data_d(data_d), .rd_d(rd_d), .flush_i(flush),
    .valid_q(vq_a), .ready_q(ready_q), .ctrl_q(ctrl_a), .data_q(data_a),
    .rd_q(rd_a), .stall_cnt_o(stall_a));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .RD_W(5), .SKID(0),
                   .CLEAR_ON_FLUSH(0), .CNT_W(3)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d(valid_d), .ready_d(rdy_b),
    .ctrl_d(ctrl_d), .data_d(data_d), .rd_d(rd_d), .flush_i(flush),
    .valid_q(vq_b), .ready_q(ready_q), .ctrl_q(ctrl_b), .data_q(data_b),
    .rd_q(rd_b), .stall_cnt_o(stall_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: per instance, a FIFO of up to 2 entries -----------
  logic [7:0]  m_ctrl [2][2];
  logic [63:0] m_data [2][2];
  logic [4:0]  m_rd   [2][2];
  int          m_cnt  [2];
  logic [63:0] m_last_data [2];
  logic [4:0]  m_last_rd   [2];
  logic        m_rdy  [2];
  int          m_stall[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_last_data[m] = '0; m_last_rd[m] = '0;
      m_rdy[m] = 1'b1; m_stall[m] = 0;
    end
  endtask

  // m=0 models the skid/clearing instance, m=1 the plain/holding instance
  task automatic model_step(input int m);
    int sz;
    bit r, inx, outx;
    sz   = m_cnt[m];
    r    = (m == 0) ? m_rdy[m] : (ready_q || sz == 0);
    inx  = valid_d && r;
    outx = (sz > 0) && ready_q;
    if (sz > 0 && !ready_q && m_stall[m] < ((m == 0) ? 65535 : 7)) m_stall[m]++;
    if (flush) begin
      m_cnt[m] = 0;
      if (m == 0) begin m_last_data[m] = '0; m_last_rd[m] = '0; end
    end else begin
      if (outx) begin
        m_ctrl[m][0] = m_ctrl[m][1]; m_data[m][0] = m_data[m][1]; m_rd[m][0] = m_rd[m][1];
        m_cnt[m]--;
      end
      if (inx) begin
        m_ctrl[m][m_cnt[m]] = ctrl_d; m_data[m][m_cnt[m]] = data_d; m_rd[m][m_cnt[m]] = rd_d;
        m_cnt[m]++;
      end
    end
    if (m_cnt[m] > 0) begin
      m_last_data[m] = m_data[m][0];
      m_last_rd[m]   = m_rd[m][0];
    end
    m_rdy[m] = (m_cnt[m] < 2);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  task automatic compare(input int m, input logic rdy, input logic v, input logic [7:0] c,
                         input logic [63:0] d, input logic [4:0] r, input int s);
    logic ev;
    ev = (m_cnt[m] > 0);
    check((m == 0) ? "a.ready_d" : "b.ready_d", 64'(rdy),
          64'((m == 0) ? m_rdy[0] : (ready_q || m_cnt[1] == 0)));
    check((m == 0) ? "a.valid_q" : "b.valid_q", 64'(v), 64'(ev));
    check((m == 0) ? "a.ctrl_q" : "b.ctrl_q", 64'(c), 64'(ev ? m_ctrl[m][0] : 8'h00));
    check((m == 0) ? "a.data_q" : "b.data_q", d, m_last_data[m]);
    check((m == 0) ? "a.rd_q" : "b.rd_q", 64'(r), 64'(m_last_rd[m]));
    check((m == 0) ? "a.stall" : "b.stall", 64'(s), 64'(m_stall[m]));
  endtask

  // Outputs settle after the falling edge; compare on the rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        compare(0, rdy_a, vq_a, ctrl_a, data_a, rd_a, int'(stall_a));
        compare(1, rdy_b, vq_b, ctrl_b, data_b, rd_b, int'(stall_b));
      end
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d,
                       input logic [4:0] r, input logic rq, input logic fl);
    valid_d = v; ctrl_d = c; data_d = d; rd_d = r; ready_q = rq; flush = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b0, 1'b0);
    cyc(); cyc();
    check("rst.a.valid", 64'(vq_a), 64'd0);
    check("rst.a.ready", 64'(rdy_a), 64'd1);
    check("rst.a.data", data_a, 64'h0);
    check("rst.b.stall", 64'(stall_b), 64'd0);
    rst_n = 1'b1;

    // 1: single transfer, latency one edge
    drive(1'b1, 8'hA5, 64'h1234, 5'd5, 1'b1, 1'b0);
    cyc();
    check("t1.a.valid", 64'(vq_a), 64'd1);
    check("t1.a.ctrl", 64'(ctrl_a), 64'hA5);
    check("t1.a.data", data_a, 64'h1234);
    check("t1.a.rd", 64'(rd_a), 64'd5);
    check("t1.b.ctrl", 64'(ctrl_b), 64'hA5);
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b1, 1'b0);
    cyc();
    check("t1.a.empty_valid", 64'(vq_a), 64'd0);
    check("t1.a.empty_ctrl", 64'(ctrl_a), 64'h0);
    check("t1.a.hold_data", data_a, 64'h1234);

    // 2: skid fill and drain in order
    drive(1'b1, 8'h11, 64'h1, 5'd1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h22, 64'h2, 5'd2, 1'b0, 1'b0);
    cyc();
    check("t2.a.ready_skid", 64'(rdy_a), 64'd0);
    check("t2.a.data_head", data_a, 64'h1);
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b1, 1'b0);
    cyc();
    check("t2.a.data_second", data_a, 64'h2);
    check("t2.a.ctrl_second", 64'(ctrl_a), 64'h22);
    check("t2.a.ready_back", 64'(rdy_a), 64'd1);
    cyc();
    check("t2.a.drained", 64'(vq_a), 64'd0);
    check("t2.a.stall", 64'(stall_a), 64'd1);

    // 3 + 5: hold on the plain instance, counter saturation at 7
    do_reset();
    drive(1'b1, 8'h3C, 64'h33, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 8'h4C, 64'h44, 5'd4, 1'b0, 1'b0);
    #1;
    check("t3.b.ready_comb", 64'(rdy_b), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t3.b.data_held", data_b, 64'h33);
      check("t3.b.valid_held", 64'(vq_b), 64'd1);
    end
    check("t3.b.stall5", 64'(stall_b), 64'd5);
    check("t3.a.stall5", 64'(stall_a), 64'd5);
    for (int i = 0; i < 5; i++) cyc();
    check("t5.b.stall_sat", 64'(stall_b), 64'd7);
    check("t5.a.stall10", 64'(stall_a), 64'd10);
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b1, 1'b0);
    cyc();
    check("t3.a.second_out", data_a, 64'h44);
    cyc();

    // 4: flush while in skid with an incoming entry
    do_reset();
    drive(1'b1, 8'h51, 64'h51, 5'd11, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h52, 64'h52, 5'd12, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h53, 64'h53, 5'd13, 1'b0, 1'b1);
    cyc();
    check("t4.a.valid", 64'(vq_a), 64'd0);
    check("t4.a.ctrl", 64'(ctrl_a), 64'h0);
    check("t4.a.data", data_a, 64'h0);
    check("t4.a.rd", 64'(rd_a), 64'd0);
    check("t4.a.ready", 64'(rdy_a), 64'd1);
    check("t4.a.stall", 64'(stall_a), 64'd2);
    check("t4.b.data_hold", data_b, 64'h51);
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b1, 1'b0);
    cyc();
    check("t4.a.nothing_emerges", 64'(vq_a), 64'd0);
    check("t4.b.nothing_emerges", 64'(vq_b), 64'd0);

    // 6: asynchronous reset between edges while in skid
    do_reset();
    drive(1'b1, 8'h61, 64'h61, 5'd21, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h62, 64'h62, 5'd22, 1'b0, 1'b0);
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6.a.valid", 64'(vq_a), 64'd0);
    check("t6.a.ready", 64'(rdy_a), 64'd1);
    check("t6.a.data", data_a, 64'h0);
    check("t6.a.stall", 64'(stall_a), 64'd0);
    check("t6.b.data", data_b, 64'h0);
    cyc();
    rst_n = 1'b1;

    // Random traffic, both variants checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), {$urandom, $urandom},
            5'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 3));
      cyc();
    end
    drive(1'b0, 8'h00, 64'h0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    check("end.a.drained", 64'(vq_a), 64'd0);
    check("end.b.drained", 64'(vq_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
